puneh_mem_arbiter: RTL and testbench
====================================

// Module: puneh_mem_arbiter
// PURPOSE
//  Arbitrates the single-port program/data memory between two requesters.
//  - CPU port: the PUNEH datapath/controller address and data bus.
//  - Loader port: program loader / debug access.
//  Serialises the requests into one memory access at a time, sequencing the
//  synchronous memory with a fixed read latency.
//  Returns read data and a one-cycle ack to the requester that won.
//  Sits between the processor top level and the memory model.
// PARAMETERS
//  ADDR_W      16  address width, both ports and memory
//  DATA_W      16  data width, both ports and memory
//  MEM_LAT     2   cycles from the mem_en cycle to valid mem_rdata (must be >=1)
//  STARVE_MAX  4   consecutive loader grants allowed while cpu_req is pending
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  rst        in   1       synchronous reset, active-high
//  cpu_req    in   1       CPU request; held with cpu_we/addr/wdata until cpu_ack
//  cpu_we     in   1       1 = write, 0 = read
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1, held until next CPU ack
//  cpu_ack    out  1       one-cycle pulse: CPU transaction complete
//  ldr_req    in   1       loader request (same rules as cpu_req)
//  ldr_we     in   1       loader write enable
//  ldr_addr   in   ADDR_W  loader address
//  ldr_wdata  in   DATA_W  loader write data
//  ldr_rdata  out  DATA_W  loader read data, valid while ldr_ack=1, held until next loader ack
//  ldr_ack    out  1       one-cycle pulse: loader transaction complete
//  mem_en     out  1       memory access strobe, exactly one cycle per transaction
//  mem_we     out  1       memory write, meaningful only with mem_en
//  mem_addr   out  ADDR_W  memory address, registered copy of the winner's address
//  mem_wdata  out  DATA_W  memory write data, registered copy of the winner's write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
//  owner_ldr  out  1       1 while the loader owns the bus (ISSUE..ACK); the processor
//                          controller uses it as a hold/stall
//  busy       out  1       1 in any state other than IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; state = IDLE; starve counter = 0.
//  States: IDLE, ISSUE, WAIT, ACK.
//  - IDLE: if any request is high, latch winner id, we, addr and wdata; go to ISSUE.
//  - ISSUE: mem_en=1 for exactly this cycle; load the wait counter with MEM_LAT; go to WAIT.
//  - WAIT: decrement the counter each cycle. When it reaches 0, capture mem_rdata
//    (reads only) into the winner's rdata register; go to ACK.
//  - ACK: pulse the winner's ack for one cycle; go to IDLE.
//  - Requests are not sampled in ISSUE, WAIT or ACK.
//  Latency: request sampled in IDLE at cycle t gives mem_en at t+1, capture at t+1+MEM_LAT,
//   and ack at t+2+MEM_LAT. For MEM_LAT=2, ack is at t+4; minimum issue spacing is 5 cycles.
//  Writes follow the same timing; the rdata registers are left unchanged on writes.
//  Handshake:
//  - The requester holds req and its operands stable until its ack.
//  - In the cycle after ack it drops req or presents a new request.
//  - A req that is still high in the IDLE cycle that follows is treated as a new transaction.
//  Arbitration, decided only in IDLE:
//  - Only one requester high: that requester wins.
//  - Both high: the loader wins unless starve counter == STARVE_MAX, in which case the CPU wins.
//  - Starve counter: +1 on each loader grant made while cpu_req=1 (saturates at STARVE_MAX).
//    Cleared on any CPU grant, and in any IDLE cycle with cpu_req=0.
//  Reset during ISSUE, WAIT or ACK: abort on the next edge and return to IDLE.
//   No ack is issued and the rdata registers are cleared.
//  A ldr_req that rises while a CPU transaction is in flight waits; it never preempts.
//  mem_addr, mem_wdata and mem_we hold their last values outside ISSUE; mem_en=0 outside ISSUE.
// TESTING
//  (all with MEM_LAT=2, STARVE_MAX=4)
//  1. CPU read: cpu_req=1, addr=0x0010, mem returns 0xBEEF.
//     -> mem_en at t+1, cpu_ack at t+4, cpu_rdata=0xBEEF, ldr_ack never rises.
//  2. Loader write: addr=0x0100, wdata=0x1234.
//     -> mem_en=mem_we=1, mem_addr=0x0100, mem_wdata=0x1234 at t+1; ldr_ack at t+4;
//        owner_ldr=1 from t+1 through t+4.
//  3. Simultaneous request, counter 0: cpu_req and ldr_req both rise at t.
//     -> loader acked at t+4; CPU granted in IDLE at t+5 and acked at t+9.
//  4. Starvation: cpu_req held while the loader issues 6 back-to-back requests.
//     -> 4 loader acks, then a CPU ack, then the remaining loader transactions.
//  5. Reset mid-WAIT: rst=1 for one cycle during a CPU read.
//     -> no cpu_ack, all outputs 0 next cycle, a new request then completes normally.
//  6. Held read data: two CPU reads returning 0xAAAA then 0x5555, with a loader write between.
//     -> cpu_rdata holds 0xAAAA until the second cpu_ack; ldr_rdata stays unchanged.

Source files
------------

// File: rtl/puneh_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory with fixed read latency.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> ACK, loader priority with CPU starvation guard.
module puneh_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner_ldr,
  output logic              busy
);

  localparam int CNT_W    = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    wait_cnt_reg;
  logic [STARVE_W-1:0] starve_reg;
  logic                win_ldr_reg;
  logic                mem_en_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [DATA_W-1:0]   cpu_rdata_reg;
  logic [DATA_W-1:0]   ldr_rdata_reg;
  logic                cpu_ack_reg;
  logic                ldr_ack_reg;
  logic                owner_ldr_reg;
  logic                busy_reg;

  logic                any_req;
  logic                cpu_starved;
  logic                grant_ldr;
  logic [STARVE_W-1:0] starve_next;

  // Grant decision, only consumed in IDLE.
  always_comb begin
    any_req     = cpu_req | ldr_req;
    cpu_starved = (starve_reg == STARVE_W'(STARVE_MAX));
    grant_ldr   = ldr_req & (~cpu_req | ~cpu_starved);
    starve_next = '0;
    if (grant_ldr && cpu_req) begin
      starve_next = cpu_starved ? starve_reg : starve_reg + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      starve_reg    <= '0;
      win_ldr_reg   <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      cpu_rdata_reg <= '0;
      ldr_rdata_reg <= '0;
      cpu_ack_reg   <= 1'b0;
      ldr_ack_reg   <= 1'b0;
      owner_ldr_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      mem_en_reg  <= 1'b0;
      cpu_ack_reg <= 1'b0;
      ldr_ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Idle cycles with cpu_req low also land here and clear the counter.
          starve_reg <= starve_next;
          if (any_req) begin
            state_reg     <= ISSUE;
            win_ldr_reg   <= grant_ldr;
            mem_en_reg    <= 1'b1;
            mem_we_reg    <= grant_ldr ? ldr_we    : cpu_we;
            mem_addr_reg  <= grant_ldr ? ldr_addr  : cpu_addr;
            mem_wdata_reg <= grant_ldr ? ldr_wdata : cpu_wdata;
            owner_ldr_reg <= grant_ldr;
            busy_reg      <= 1'b1;
          end
        end
        ISSUE: begin
          wait_cnt_reg <= CNT_W'(MEM_LAT);
          state_reg    <= WAIT;
        end
        WAIT: begin
          // Counter value 1 here means it reaches 0 on this edge: data is on mem_rdata now.
          if (wait_cnt_reg == CNT_W'(1)) begin
            if (!mem_we_reg) begin
              if (win_ldr_reg) begin
                ldr_rdata_reg <= mem_rdata;
              end else begin
                cpu_rdata_reg <= mem_rdata;
              end
            end
            cpu_ack_reg  <= ~win_ldr_reg;
            ldr_ack_reg  <= win_ldr_reg;
            wait_cnt_reg <= '0;
            state_reg    <= ACK;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
          end
        end
        ACK: begin
          owner_ldr_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_reg;
  assign cpu_ack   = cpu_ack_reg;
  assign ldr_rdata = ldr_rdata_reg;
  assign ldr_ack   = ldr_ack_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign owner_ldr = owner_ldr_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_puneh_mem_arbiter.sv
// Single-threaded bench: per-cycle transaction-level model + memory model, directed scenarios.
module tb_puneh_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  localparam int EV_CACK = 0;
  localparam int EV_LACK = 1;
  localparam int EV_EN   = 2;
  localparam int EV_OWN  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          ldr_req = 1'b0, ldr_we = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;
  logic [DW-1:0] ldr_rdata;
  logic          ldr_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          owner_ldr, busy;

  puneh_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner_ldr(owner_ldr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    int            kind;
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  txn_t cpu_q[$];
  txn_t ldr_q[$];
  ev_t  ev_log[$];
  int   cpu_idx = 0, ldr_idx = 0;
  int   cpu_t = 0, ldr_t = 0;
  bit   cpu_got = 0, ldr_got = 0, abort = 0;

  logic [DW-1:0] mem [0:65535];
  bit            pv [0:LAT];
  logic [DW-1:0] pd [0:LAT];

  // Model: one transaction at a time, described by its grant cycle rather than a state.
  bit            m_active = 0, m_wl = 0, m_we = 0, seen_rst = 0;
  int            m_g = 0, m_starve = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_cpu_rd = '0, m_ldr_rd = '0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%s exp=%s", name, act, exp);
    end
  endtask

  // Negedge work: compare this cycle, log events, run memory, advance model.
  task automatic step();
    bit exp_ack;
    ev_t e;
    if (seen_rst) begin
      exp_ack = m_active && (cyc == m_g + 2 + LAT);
      chk("mem_en",    mem_en,    m_active && (cyc == m_g + 1));
      chk("mem_we",    mem_we,    m_we);
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("cpu_ack",   cpu_ack,   exp_ack && !m_wl);
      chk("ldr_ack",   ldr_ack,   exp_ack && m_wl);
      chk("cpu_rdata", cpu_rdata, m_cpu_rd);
      chk("ldr_rdata", ldr_rdata, m_ldr_rd);
      chk("owner_ldr", owner_ldr, m_active && m_wl);
      chk("busy",      busy,      m_active);
    end
    e.cyc = cyc; e.we = mem_we; e.addr = mem_addr; e.data = mem_wdata;
    if (cpu_ack === 1'b1)   begin e.kind = EV_CACK; ev_log.push_back(e); end
    if (ldr_ack === 1'b1)   begin e.kind = EV_LACK; ev_log.push_back(e); end
    if (mem_en === 1'b1)    begin e.kind = EV_EN;   ev_log.push_back(e); end
    if (owner_ldr === 1'b1) begin e.kind = EV_OWN;  ev_log.push_back(e); end
    cpu_got = cpu_req && (cpu_ack === 1'b1);
    ldr_got = ldr_req && (ldr_ack === 1'b1);

    // Memory: read data appears only in the cycle MEM_LAT after mem_en, junk otherwise.
    for (int k = LAT; k >= 1; k--) begin
      pv[k] = pv[k-1];
      pd[k] = pd[k-1];
    end
    pv[0] = (mem_en === 1'b1) && (mem_we === 1'b0);
    pd[0] = pv[0] ? mem[mem_addr] : '0;
    if ((mem_en === 1'b1) && (mem_we === 1'b1)) mem[mem_addr] = mem_wdata;
    mem_rdata = pv[LAT] ? pd[LAT] : {cyc[7:0], 8'hC3};

    if (rst) begin
      seen_rst = 1; m_active = 0; m_starve = 0; m_wl = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_ldr_rd = '0;
    end else if (!m_active) begin
      if (cpu_req || ldr_req) begin
        m_wl = ldr_req && !(cpu_req && m_starve == SMAX);
        if (m_wl && cpu_req) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
        else                 m_starve = 0;
        m_active = 1; m_g = cyc;
        m_we    = m_wl ? ldr_we    : cpu_we;
        m_addr  = m_wl ? ldr_addr  : cpu_addr;
        m_wdata = m_wl ? ldr_wdata : cpu_wdata;
      end else begin
        m_starve = 0;
      end
    end else begin
      if (cyc == m_g + 1 + LAT && !m_we) begin
        if (m_wl) m_ldr_rd = mem[m_addr];
        else      m_cpu_rd = mem[m_addr];
      end
      if (cyc == m_g + 2 + LAT) m_active = 0;
    end
    cyc++;
  endtask

  // Posedge+1 work: requesters drop or advance after their ack, otherwise hold.
  task automatic drive();
    if (abort) begin
      cpu_req = 0; ldr_req = 0;
      cpu_idx = cpu_q.size(); ldr_idx = ldr_q.size();
      return;
    end
    if (cpu_got) begin cpu_idx++; cpu_req = 0; end
    if (ldr_got) begin ldr_idx++; ldr_req = 0; end
    if (!cpu_req && cpu_idx < cpu_q.size()) begin
      cpu_req = 1; cpu_we = cpu_q[cpu_idx].we;
      cpu_addr = cpu_q[cpu_idx].addr; cpu_wdata = cpu_q[cpu_idx].wdata; cpu_t = cyc;
    end
    if (!ldr_req && ldr_idx < ldr_q.size()) begin
      ldr_req = 1; ldr_we = ldr_q[ldr_idx].we;
      ldr_addr = ldr_q[ldr_idx].addr; ldr_wdata = ldr_q[ldr_idx].wdata; ldr_t = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input string name, input int limit);
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      tick();
      done = (cpu_idx == cpu_q.size()) && (ldr_idx == ldr_q.size()) && !cpu_req && !ldr_req;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout after %0d cycles", name, limit);
      abort = 1; tick(); abort = 0;
    end
    tick(); tick();
  endtask

  task automatic push_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    cpu_q.push_back(t);
  endtask

  task automatic push_ldr(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    ldr_q.push_back(t);
  endtask

  function automatic int ev_count(input int from, input int kind);
    int n = 0;
    for (int i = from; i < ev_log.size(); i++) if (ev_log[i].kind == kind) n++;
    return n;
  endfunction

  function automatic int ev_first(input int from, input int kind);
    for (int i = from; i < ev_log.size(); i++) if (ev_log[i].kind == kind) return i;
    return -1;
  endfunction

  function automatic int ev_cyc(input int idx);
    if (idx < 0) return -1;
    return ev_log[idx].cyc;
  endfunction

  initial begin
    int base, idx, last_own, t0;
    string order;
    for (int i = 0; i < 65536; i++) mem[i] = i[15:0] ^ 16'h5A5A;
    for (int k = 0; k <= LAT; k++) begin pv[k] = 0; pd[k] = '0; end
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0020] = 16'hAAAA;
    mem[16'h0030] = 16'h5555;

    rst = 1;
    repeat (3) tick();
    rst = 0;
    chk("reset_busy", busy, 1'b0);
    chk("reset_mem_en", mem_en, 1'b0);
    chk("reset_cpu_rdata", cpu_rdata, 16'h0000);
    chk("reset_owner", owner_ldr, 1'b0);
    tick();

    // 1: CPU read
    base = ev_log.size();
    push_cpu(1'b0, 16'h0010, 16'h0000);
    run("t1", 40);
    $display("T1 cpu read t=%0d ack=%0d rdata=%h", cpu_t, ev_cyc(ev_first(base, EV_CACK)), cpu_rdata);
    chk("t1_en_cyc", ev_cyc(ev_first(base, EV_EN)), cpu_t + 1);
    chk("t1_ack_cyc", ev_cyc(ev_first(base, EV_CACK)), cpu_t + 4);
    chk("t1_rdata", cpu_rdata, 16'hBEEF);
    chk("t1_no_ldr_ack", ev_count(base, EV_LACK), 0);

    // 2: loader write
    base = ev_log.size();
    push_ldr(1'b1, 16'h0100, 16'h1234);
    run("t2", 40);
    idx = ev_first(base, EV_EN);
    last_own = -1;
    for (int i = base; i < ev_log.size(); i++) if (ev_log[i].kind == EV_OWN) last_own = ev_log[i].cyc;
    $display("T2 ldr write t=%0d en=%0d ack=%0d", ldr_t, ev_cyc(idx), ev_cyc(ev_first(base, EV_LACK)));
    chk("t2_en_cyc", ev_cyc(idx), ldr_t + 1);
    chk("t2_en_we", (idx >= 0) ? ev_log[idx].we : 1'b0, 1'b1);
    chk("t2_en_addr", (idx >= 0) ? ev_log[idx].addr : 16'h0, 16'h0100);
    chk("t2_en_wdata", (idx >= 0) ? ev_log[idx].data : 16'h0, 16'h1234);
    chk("t2_ack_cyc", ev_cyc(ev_first(base, EV_LACK)), ldr_t + 4);
    chk("t2_own_first", ev_cyc(ev_first(base, EV_OWN)), ldr_t + 1);
    chk("t2_own_last", last_own, ldr_t + 4);
    chk("t2_own_count", ev_count(base, EV_OWN), 4);

    // 3: simultaneous requests, loader first, CPU five cycles later
    base = ev_log.size();
    push_cpu(1'b0, 16'h0010, 16'h0000);
    push_ldr(1'b0, 16'h0100, 16'h0000);
    run("t3", 40);
    $display("T3 both t=%0d ldr_ack=%0d cpu_ack=%0d", ldr_t, ev_cyc(ev_first(base, EV_LACK)),
             ev_cyc(ev_first(base, EV_CACK)));
    chk("t3_ldr_ack", ev_cyc(ev_first(base, EV_LACK)), ldr_t + 4);
    chk("t3_cpu_ack", ev_cyc(ev_first(base, EV_CACK)), ldr_t + 9);

    // 4: starvation guard
    base = ev_log.size();
    push_cpu(1'b0, 16'h0010, 16'h0000);
    for (int i = 0; i < 6; i++) push_ldr(1'b1, 16'h0200 + 16'(i), 16'h0A00 + 16'(i));
    run("t4", 120);
    order = "";
    for (int i = base; i < ev_log.size(); i++) begin
      if (ev_log[i].kind == EV_CACK) order = {order, "C"};
      if (ev_log[i].kind == EV_LACK) order = {order, "L"};
    end
    $display("T4 starvation ack order %s", order);
    chk_str("t4_order", order, "LLLLCLL");

    // 5: reset while a CPU read is in WAIT
    base = ev_log.size();
    push_cpu(1'b0, 16'h0020, 16'h0000);
    tick();
    t0 = cpu_t;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t5_busy", busy, 1'b0);
    chk("t5_mem_addr", mem_addr, 16'h0000);
    chk("t5_cpu_rdata", cpu_rdata, 16'h0000);
    chk("t5_ldr_rdata", ldr_rdata, 16'h0000);
    chk("t5_cpu_ack", cpu_ack, 1'b0);
    run("t5", 40);
    $display("T5 reset mid-wait t=%0d ack=%0d rdata=%h", t0, ev_cyc(ev_first(base, EV_CACK)), cpu_rdata);
    chk("t5_ack_count", ev_count(base, EV_CACK), 1);
    chk("t5_ack_cyc", ev_cyc(ev_first(base, EV_CACK)), t0 + 7);
    chk("t5_rdata", cpu_rdata, 16'hAAAA);

    // 6: read data held across another requester's transaction
    push_ldr(1'b0, 16'h0100, 16'h0000);
    run("t6a", 40);
    chk("t6_ldr_rd", ldr_rdata, 16'h1234);
    push_cpu(1'b0, 16'h0020, 16'h0000);
    run("t6b", 40);
    chk("t6_cpu_rd1", cpu_rdata, 16'hAAAA);
    push_ldr(1'b1, 16'h0040, 16'h7777);
    run("t6c", 40);
    $display("T6 after ldr write cpu_rdata=%h ldr_rdata=%h", cpu_rdata, ldr_rdata);
    chk("t6_cpu_held", cpu_rdata, 16'hAAAA);
    chk("t6_ldr_held", ldr_rdata, 16'h1234);
    push_cpu(1'b0, 16'h0030, 16'h0000);
    run("t6d", 40);
    $display("T6 second cpu read cpu_rdata=%h ldr_rdata=%h", cpu_rdata, ldr_rdata);
    chk("t6_cpu_rd2", cpu_rdata, 16'h5555);
    chk("t6_ldr_final", ldr_rdata, 16'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
